// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack memory
// handshake and hands them to the control unit over valid/ready.
module instr_fetch_unit #(
  parameter int                     ADDR_WIDTH = 20,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = {ADDR_WIDTH{1'b0}},
  parameter int                     TIMEOUT    = 16,
  parameter logic [6:0]             HLT_OPCODE = 7'd26
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_data,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic [2:0]            pc_control,
  input  logic                  cond_flag,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  fetch_error
);

  localparam int              CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;

  // Branch resolution; sequential increment wraps naturally at the address width.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(
    input logic [ADDR_WIDTH-1:0] cur,
    input logic [2:0]            ctrl,
    input logic                  cond,
    input logic [ADDR_WIDTH-1:0] target
  );
    logic [ADDR_WIDTH-1:0] inc;
    inc = cur + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    case (ctrl)
      3'd1:    next_pc = target;
      3'd2:    next_pc = cond ? target : inc;
      3'd3:    next_pc = cond ? inc : target;
      3'd4:    next_pc = cur;
      default: next_pc = inc;
    endcase
  endfunction

  // Fetch state machine with all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= 32'h0000_0000;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_error <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r   <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
          count_r   <= {CW{1'b0}};
        end
        FETCH: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (imem_ack) begin
            instr       <= imem_data;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            count_r     <= {CW{1'b0}};
            state_r     <= ISSUE;
          end else if (count_r == LAST) begin
            imem_req    <= 1'b0;
            fetch_error <= 1'b1;
            halted      <= 1'b1;
            state_r     <= HALT;
          end else begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (instr[31:25] == HLT_OPCODE) begin
              halted  <= 1'b1;
              state_r <= HALT;
            end else begin
              pc        <= next_pc(pc, pc_control, cond_flag, branch_target);
              imem_addr <= next_pc(pc, pc_control, cond_flag, branch_target);
              imem_req  <= 1'b1;
              count_r   <= {CW{1'b0}};
              state_r   <= FETCH;
            end
          end else begin
            state_r <= ISSUE;
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state_r     <= HALT;
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
